// File: rtl/mem_ctrl_pkg.sv
// Shared types and sizing for the memory access front end.
package mem_ctrl_pkg;

  localparam int unsigned ADDR_W         = 8;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned LANE_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRD   = 2'd2,
    DWR   = 2'd3
  } state_t;

endpackage

// File: rtl/word_assembler.sv
// Byte-lane register that builds a little-endian instruction word.
// Lower lanes are staged so the visible word only changes when the last byte lands.
module word_assembler
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cap_en,
  input  logic [LANE_W-1:0] lane,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

  logic [BYTES_PER_WORD-2:0][BYTE_W-1:0] shadow_q;

  // Stage lanes 0..N-2, publish the full word on the final lane.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      word     <= '0;
    end else if (cap_en) begin
      if (lane == LAST_LANE) begin
        word <= {byte_in, shadow_q};
      end else begin
        shadow_q[lane] <= byte_in;
      end
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences instruction fetches (4 pipelined byte reads) and single-byte data
// accesses onto a synchronous-read byte memory; all memory-side outputs registered.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W         = mem_ctrl_pkg::ADDR_W,
  parameter int unsigned BYTES_PER_WORD = mem_ctrl_pkg::BYTES_PER_WORD
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        fetch_req,
  input  logic [ADDR_W-1:0]           fetch_addr,
  output logic                        fetch_done,
  output logic [8*BYTES_PER_WORD-1:0] instr,
  input  logic                        data_req,
  input  logic                        data_we,
  input  logic [ADDR_W-1:0]           data_addr,
  input  logic [7:0]                  data_wdata,
  output logic                        data_done,
  output logic [7:0]                  data_rdata,
  output logic                        busy,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [7:0]                  mem_wdata,
  output logic                        mem_we,
  input  logic [7:0]                  mem_rdata
);

  import mem_ctrl_pkg::*;

  localparam int unsigned      CNT_W     = $clog2(BYTES_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(BYTES_PER_WORD - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   issue_q, issue_d;
  logic [CNT_W-1:0]   cap_q, cap_d;
  logic [ADDR_W-1:0]  mem_addr_d;
  logic [7:0]         mem_wdata_d;
  logic               mem_we_d;
  logic               busy_d;
  logic               fetch_done_d;
  logic               data_done_d;
  logic [7:0]         data_rdata_d;
  logic               cap_en_c;

  // Next-state and next-output decode.
  always_comb begin
    state_d      = state_q;
    issue_d      = issue_q;
    cap_d        = cap_q;
    mem_addr_d   = mem_addr;
    mem_wdata_d  = mem_wdata;
    mem_we_d     = 1'b0;
    fetch_done_d = 1'b0;
    data_done_d  = 1'b0;
    data_rdata_d = data_rdata;
    cap_en_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (data_req) begin
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
          mem_we_d    = data_we;
          issue_d     = '0;
          state_d     = data_we ? DWR : DRD;
        end else if (fetch_req) begin
          mem_addr_d = fetch_addr;
          issue_d    = '0;
          cap_d      = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        // issue_q is the offset currently on mem_addr; it parks at the last lane.
        if (issue_q != LAST_LANE) begin
          mem_addr_d = mem_addr + ADDR_W'(1);
          issue_d    = issue_q + CNT_W'(1);
        end
        // Read data trails its address by one edge, so capture starts once offset 1 is out.
        if (issue_q != '0) begin
          cap_en_c = 1'b1;
          cap_d    = cap_q + CNT_W'(1);
          if (cap_q == LAST_LANE) begin
            fetch_done_d = 1'b1;
            state_d      = IDLE;
          end
        end
      end
      DRD: begin
        // First cycle waits for the memory to sample the address.
        if (issue_q == '0) begin
          issue_d = CNT_W'(1);
        end else begin
          data_rdata_d = mem_rdata;
          data_done_d  = 1'b1;
          state_d      = IDLE;
        end
      end
      DWR: begin
        data_done_d = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      issue_q    <= '0;
      cap_q      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      busy       <= 1'b0;
      fetch_done <= 1'b0;
      data_done  <= 1'b0;
      data_rdata <= '0;
    end else begin
      state_q    <= state_d;
      issue_q    <= issue_d;
      cap_q      <= cap_d;
      mem_addr   <= mem_addr_d;
      mem_wdata  <= mem_wdata_d;
      mem_we     <= mem_we_d;
      busy       <= busy_d;
      fetch_done <= fetch_done_d;
      data_done  <= data_done_d;
      data_rdata <= data_rdata_d;
    end
  end

  word_assembler u_word_assembler (
    .clk     (clk),
    .reset   (reset),
    .cap_en  (cap_en_c),
    .lane    (cap_q),
    .byte_in (mem_rdata),
    .word    (instr)
  );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 256x8 synchronous-read memory.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [7:0]  fetch_addr;
  logic        fetch_done;
  logic [31:0] instr;
  logic        data_req;
  logic        data_we;
  logic [7:0]  data_addr;
  logic [7:0]  data_wdata;
  logic        data_done;
  logic [7:0]  data_rdata;
  logic        busy;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  logic        bd_we;
  logic [7:0]  bd_addr;
  logic [7:0]  bd_data;
  logic [7:0]  mem [0:255];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_done (fetch_done),
    .instr      (instr),
    .data_req   (data_req),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_done  (data_done),
    .data_rdata (data_rdata),
    .busy       (busy),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: backdoor preload port, DUT write port, registered read.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bd_write(input logic [7:0] a, input logic [7:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    tick();
    bd_we   = 1'b0;
  endtask

  // Fetch from a, expecting exp; first tick is the accept edge E0.
  task automatic run_fetch(input logic [7:0] a, input logic [31:0] exp);
    logic [7:0] ea;
    fetch_req  = 1'b1;
    fetch_addr = a;
    for (int k = 0; k <= 5; k++) begin
      tick();
      if (k == 1) fetch_addr = a + 8'h10;
      if (k <= 3) begin
        ea = a + 8'(k);
        check($sformatf("fetch%0h_addr_E%0d", a, k), 32'(mem_addr), 32'(ea));
      end
      check($sformatf("fetch%0h_we_E%0d", a, k), 32'(mem_we), 32'd0);
      check($sformatf("fetch%0h_done_E%0d", a, k), 32'(fetch_done), (k == 5) ? 32'd1 : 32'd0);
      check($sformatf("fetch%0h_busy_E%0d", a, k), 32'(busy), (k == 5) ? 32'd0 : 32'd1);
    end
    check($sformatf("fetch%0h_instr", a), instr, exp);
    fetch_req = 1'b0;
    tick();
    check($sformatf("fetch%0h_done_clear", a), 32'(fetch_done), 32'd0);
    check($sformatf("fetch%0h_instr_hold", a), instr, exp);
  endtask

  initial begin
    reset      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = 8'h00;
    data_req   = 1'b0;
    data_we    = 1'b0;
    data_addr  = 8'h00;
    data_wdata = 8'h00;
    bd_we      = 1'b0;
    bd_addr    = 8'h00;
    bd_data    = 8'h00;

    // Preload memory while reset holds the DUT idle.
    bd_write(8'h10, 8'h8C);
    bd_write(8'h11, 8'h41);
    bd_write(8'h12, 8'h00);
    bd_write(8'h13, 8'h04);
    bd_write(8'hFE, 8'h11);
    bd_write(8'hFF, 8'h22);
    bd_write(8'h00, 8'h33);
    bd_write(8'h01, 8'h44);

    check("rst_instr", instr, 32'h0);
    check("rst_data_rdata", 32'(data_rdata), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_fetch_done", 32'(fetch_done), 32'h0);
    check("rst_data_done", 32'(data_done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();

    // Plain fetch with an address change after accept.
    run_fetch(8'h10, 32'h0400418C);

    // Fetch that wraps the address space.
    run_fetch(8'hFE, 32'h44332211);

    // Store then load the same byte.
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_addr  = 8'h80;
    data_wdata = 8'h5A;
    tick();
    check("st_addr_E0", 32'(mem_addr), 32'h80);
    check("st_wdata_E0", 32'(mem_wdata), 32'h5A);
    check("st_we_E0", 32'(mem_we), 32'h1);
    check("st_busy_E0", 32'(busy), 32'h1);
    check("st_done_E0", 32'(data_done), 32'h0);
    data_wdata = 8'hA5;
    tick();
    check("st_we_E1", 32'(mem_we), 32'h0);
    check("st_done_E1", 32'(data_done), 32'h1);
    check("st_busy_E1", 32'(busy), 32'h0);
    data_we   = 1'b0;
    data_addr = 8'h80;
    tick();
    check("ld_addr_E0", 32'(mem_addr), 32'h80);
    check("ld_we_E0", 32'(mem_we), 32'h0);
    check("ld_busy_E0", 32'(busy), 32'h1);
    check("ld_done_E0", 32'(data_done), 32'h0);
    tick();
    check("ld_done_E1", 32'(data_done), 32'h0);
    check("ld_we_E1", 32'(mem_we), 32'h0);
    tick();
    check("ld_done_E2", 32'(data_done), 32'h1);
    check("ld_rdata_E2", 32'(data_rdata), 32'h5A);
    check("ld_busy_E2", 32'(busy), 32'h0);
    data_req = 1'b0;
    tick();
    check("ld_done_clear", 32'(data_done), 32'h0);
    check("ld_rdata_hold", 32'(data_rdata), 32'h5A);

    // Simultaneous requests: the load wins, the fetch follows.
    data_req   = 1'b1;
    data_we    = 1'b0;
    data_addr  = 8'h11;
    fetch_req  = 1'b1;
    fetch_addr = 8'h10;
    tick();
    check("prio_addr_E0", 32'(mem_addr), 32'h11);
    check("prio_busy_E0", 32'(busy), 32'h1);
    tick();
    tick();
    check("prio_data_done", 32'(data_done), 32'h1);
    check("prio_rdata", 32'(data_rdata), 32'h41);
    check("prio_no_fetch_done", 32'(fetch_done), 32'h0);
    data_req = 1'b0;
    run_fetch(8'h10, 32'h0400418C);

    // Reset during a fetch, then a clean fetch afterwards.
    fetch_req  = 1'b1;
    fetch_addr = 8'hFE;
    tick();
    tick();
    tick();
    check("mid_addr_E2", 32'(mem_addr), 32'h00);
    reset = 1'b1;
    #1;
    check("mid_rst_instr", instr, 32'h0);
    check("mid_rst_mem_addr", 32'(mem_addr), 32'h0);
    check("mid_rst_mem_we", 32'(mem_we), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_fetch_done", 32'(fetch_done), 32'h0);
    check("mid_rst_data_rdata", 32'(data_rdata), 32'h0);
    fetch_req = 1'b0;
    tick();
    tick();
    check("mid_rst_no_done", 32'(fetch_done), 32'h0);
    reset = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'h0);
    run_fetch(8'hFE, 32'h44332211);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Byte-sequencing front end that sits directly upstream of the 256 x 8-bit unified instruction/data memory (`mem`) and is the only master of that memory. It turns a 32-bit instruction-fetch request into four pipelined byte reads and assembles the word. It turns a data load/store request into a single byte access. All memory-side outputs are registered, so the synchronous-read memory sees clean, glitch-free address and write-enable.

## Interface
Parameters:
- `ADDR_W`, 8, memory address width (256 bytes)
- `BYTES_PER_WORD`, 4, bytes assembled per instruction fetch

Ports:
- `clk`  in  1  single clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `fetch_req`  in  1  level request for a 32-bit instruction; held until `fetch_done`
- `fetch_addr`  in  8  byte address of instruction byte 0; latched at accept
- `fetch_done`  out  1  one-cycle pulse; `instr` valid from this cycle
- `instr`  out  32  assembled instruction
- `data_req`  in  1  level request for a byte access; held until `data_done`
- `data_we`  in  1  1 = store, 0 = load; latched at accept
- `data_addr`  in  8  byte address; latched at accept
- `data_wdata`  in  8  store data; latched at accept
- `data_done`  out  1  one-cycle pulse; for a load, `data_rdata` is valid from this cycle
- `data_rdata`  out  8  load result
- `busy`  out  1  high whenever state is not IDLE
- `mem_addr`  out  8  to memory `addr`
- `mem_wdata`  out  8  to memory `data_in`
- `mem_we`  out  1  to memory `memwrite`
- `mem_rdata`  in  8  from memory `data_out`; valid the cycle after the edge that sampled `mem_addr`

## Operation
- States: IDLE, FETCH, DRD (data read capture), DWR (data write).
- In IDLE, requests are sampled each edge.
  - `data_req` has priority over `fetch_req` when both are high.
  - On accept, address, write data and write-enable are latched into the memory-side output registers.
- FETCH uses a 2-bit issue counter and a 2-bit capture counter.
  - Addresses issued: A, A+1, A+2, A+3, computed mod 256 (A=8'hFE wraps to 8'hFF, 8'h00, 8'h01).
  - Byte k is placed in `instr[8k+7:8k]` (little-endian).
- DRD captures `mem_rdata` into `data_rdata`.
- DWR holds `mem_we`=1 for exactly one cycle.
- `instr` and `data_rdata` hold their last value until overwritten by the next completed access of the same kind.
- Request inputs are ignored while `busy`. Address or data changes after accept have no effect.
- `mem_we` is never high outside DWR, and is low during every fetch.

## Timing
Edges are counted from the accept edge E0.
- Reset value of every output is 0: `instr`, `data_rdata`, `mem_addr`, `mem_wdata`, `mem_we`, `fetch_done`, `data_done`, `busy`. State resets to IDLE.
- Fetch:
  - E0: `mem_addr`=A.
  - E1: A+1.
  - E2: capture byte0, A+2.
  - E3: capture byte1, A+3.
  - E4: capture byte2.
  - E5: capture byte3, `fetch_done`=1 for one cycle, return to IDLE.
  - Latency: 5 cycles.
- Load:
  - E0: `mem_addr`=A, `mem_we`=0.
  - E2: capture, `data_done`=1, return to IDLE.
  - Latency: 2 cycles.
- Store:
  - E0: `mem_addr`=A, `mem_wdata`=D, `mem_we`=1.
  - E1: memory writes, `mem_we`→0, `data_done`=1, return to IDLE.
  - Latency: 1 cycle.
- A new request is accepted on the first edge after returning to IDLE while the request is high. Because requests are held until their done pulse, a requester must deassert in the done cycle to avoid a repeat.
- Reset asserted mid-operation:
  - Immediately forces `mem_we`=0, so no write occurs at subsequent edges.
  - Partial `instr` is cleared to 0.
  - No done pulse is emitted.
- `busy` is registered with the state: high from E0+ until the done edge.

## Structure
- Shared package `mem_ctrl_pkg`:
  - state enum (IDLE, FETCH, DRD, DWR)
  - `ADDR_W`=8
  - `BYTES_PER_WORD`=4
  - `WORD_W`=32
- One natural sub-module, `word_assembler`: a 4 x 8-bit byte-lane register with capture-enable and lane-select, producing `instr`.
- Everything else (FSM, counters, output registers) lives in the top module.

## Test plan
- Preload memory[0x10..0x13]=0x8C,0x41,0x00,0x04; fetch A=0x10 -> `fetch_done` at E5, `instr`=32'h0400418C, `mem_we` never high.
- Fetch A=0xFE with memory[FE,FF,00,01]=11,22,33,44 -> `mem_addr` sequence FE,FF,00,01; `instr`=32'h44332211.
- Store A=0x80 D=0x5A, then load A=0x80 -> store `data_done` at E1, `mem_we` high exactly one cycle; load `data_done` at E2 with `data_rdata`=0x5A.
- `data_req` and `fetch_req` both high in IDLE -> data access served first; fetch accepted on the edge after `data_done`.
- Assert `reset` at E2 of a fetch -> all outputs 0 immediately, no `fetch_done`; a fresh fetch after release completes normally.
- Change `fetch_addr` from 0x10 to 0x20 at E1 -> issued addresses remain 0x10..0x13.
